sha256_bus_loader: RTL and testbench
====================================

Name: sha256_bus_loader

Overview:
- Upstream bus-side loader for the SHA-256/XMSS hashing wrapper.
- Assembles the 1024-bit input block from 32-bit word writes and holds the 3-bit command and mode flags.
- Issues a one-cycle start with its init pulses, tracks busy/done, then captures the 256-bit digest into readable result words.
- Sits between the SoC peripheral bus and the hashing wrapper.

Parameters:
- WORDS, 32, number of 32-bit words in the input block (1024/32); fixed, informational.
- RES_WORDS, 8, number of 32-bit result words (256/32).
- BUSY_TIMEOUT, 16, cycles allowed after start for module_busy to assert before an error is flagged.

Ports:
- io_mainClk  in  1  single clock
- io_systemReset  in  1  synchronous, active-low reset
- bus_wr_valid  in  1  write request
- bus_wr_ready  out  1  write accepted when valid&ready
- bus_wr_addr  in  6  0..31 data word, 32 command, 33 clear status
- bus_wr_data  in  32  write data
- bus_rd_addr  in  4  0..7 result word, 8 status
- bus_rd_data  out  32  combinational read data
- cmd_reg  out  3  001 plain SHA-256, 010 XMSS
- input_data_reg  out  1024  assembled block
- sha256XMSS_start_reg, sha256_sha256_start_reg  out  1  start pulses
- sha256XMSS_init_iv, sha256_sha256_init_iv, sha256_sha256_init_message  out  1  init pulses
- sha256XMSS_second_block_data_available, sha256XMSS_message_length, sha256XMSS_store_intermediate, sha256XMSS_continue_intermediate  out  1  level flags
- sha256XMSS_done  in  1  XMSS completion pulse
- output_data  in  256  digest from the hashing wrapper
- module_busy  in  1  wrapper busy
- irq  out  1  level; high while result_valid or error

Behaviour:
- Reset (io_systemReset==0 at a clock edge):
  - input_data_reg, cmd_reg, all flags, pulses, result words, status and irq go to 0.
  - State goes to IDLE.
  - Reset mid-operation aborts immediately; the wrapper must be reset by the same signal.
- Word k written at address k maps to input_data_reg[1023-32k -: 32], i.e. word 0 is the MSW.
- The command word is written at address 32:
  - bits[2:0] cmd
  - bit3 start
  - bit4 init_iv
  - bit5 init_message
  - bit6 second_block
  - bit7 message_length
  - bit8 store_intermediate
  - bit9 continue_intermediate
- bus_wr_ready=1 only in IDLE. In any other state, writes stall and nothing changes.
- States:
  - IDLE:
    - Command write latches cmd_reg and the level flags (bits 6..9).
    - If bit3=1 and cmd is 001 or 010, go to LAUNCH and clear result_valid and error.
    - If bit3=1 and cmd is any other value, set error (status bit2) and stay in IDLE.
  - LAUNCH (exactly 1 cycle):
    - Assert sha256_sha256_start_reg when cmd=001, sha256XMSS_start_reg when cmd=010.
    - Init pulses assert in the same cycle: init_iv goes to the XMSS or plain port by cmd; init_message only for cmd=001.
    - Next state WAIT_BUSY; the timeout counter is cleared.
  - WAIT_BUSY:
    - module_busy=1 -> WAIT_DONE.
    - Counter reaches BUSY_TIMEOUT with no busy -> set error, go to IDLE.
    - For cmd=010, sha256XMSS_done seen here counts as completion -> CAPTURE.
  - WAIT_DONE:
    - cmd=010: sha256XMSS_done=1 -> CAPTURE.
    - cmd=001: module_busy=0 -> CAPTURE.
  - CAPTURE (1 cycle):
    - output_data[255-32j -: 32] is registered into result word j.
    - result_valid (status bit0) is set; state returns to IDLE.
- Status word at bus_rd_addr 8:
  - bit0 result_valid
  - bit1 busy (state != IDLE)
  - bit2 error
  - bits[6:4] current state encoding
- bus_rd_addr 9..15 read 0.
- Write to address 33 clears result_valid and error (IDLE only).
- Latency: start command accepted at cycle t; start pulse at t+1; result_valid at (done or busy-fall cycle)+1.
- Simultaneous events:
  - A command start in the same cycle as a data-word write is impossible: single address per beat.
  - A done pulse and busy falling together are treated as a single completion.
- Data words may be rewritten between runs; input_data_reg holds its value during a run.
- Pulses are never asserted for more than 1 cycle.

Decomposition:
- Shared package holds:
  - the CMD_SHA256=3'b001 and CMD_XMSS=3'b010 constants
  - the address map (ADDR_CMD=32, ADDR_CLR=33, ADDR_STATUS=8)
  - command bit indices
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE)
- One natural sub-module: sha256_bus_loader_result, the 8x32 result capture register file with read mux.

Test Plan:
- Write the 16 "abc"-padded words (0x61626380, 0…, 0x00000018) to addresses 0..15, then command 0x039 (cmd=001, start, init_iv, init_message) with a behavioural wrapper -> one sha256_sha256_start_reg pulse; result words 0..7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; status=0x01.
- XMSS run with command 0x00A (cmd=010, start); model asserts done after 40 cycles -> exactly one sha256XMSS_start_reg pulse; capture 1 cycle after done; busy bit reads 1 during the run.
- Start with no busy response -> error set at BUSY_TIMEOUT+2 cycles after command; irq=1; write to address 33 clears status to 0.
- Command 0x00F (cmd=111, start) -> no start pulse; error=1; state stays IDLE.
- Data write during WAIT_DONE -> bus_wr_ready=0; input_data_reg unchanged; the write completes after return to IDLE.
- Assert io_systemReset=0 in WAIT_DONE -> next cycle: all outputs 0, state IDLE, result words 0.

Source files
------------

// File: rtl/sha256_bus_loader_pkg.sv
// Shared definitions for the SHA-256/XMSS bus loader: command codes, bus address
// map, command-word bit positions and the loader state encoding. The state
// encoding is visible to software in status bits [6:4].
package sha256_bus_loader_pkg;

    // Command codes carried in command word bits [2:0]
    localparam logic [2:0] CMD_SHA256 = 3'b001;
    localparam logic [2:0] CMD_XMSS   = 3'b010;

    // Bus address map
    localparam logic [5:0] ADDR_CMD    = 6'd32;
    localparam logic [5:0] ADDR_CLR    = 6'd33;
    localparam logic [3:0] ADDR_STATUS = 4'd8;

    // Command word bit positions
    localparam int unsigned CMD_BIT_START        = 3;
    localparam int unsigned CMD_BIT_INIT_IV      = 4;
    localparam int unsigned CMD_BIT_INIT_MSG     = 5;
    localparam int unsigned CMD_BIT_SECOND_BLOCK = 6;
    localparam int unsigned CMD_BIT_MSG_LEN      = 7;
    localparam int unsigned CMD_BIT_STORE_INT    = 8;
    localparam int unsigned CMD_BIT_CONT_INT     = 9;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLaunch   = 3'd1,
        StWaitBusy = 3'd2,
        StWaitDone = 3'd3,
        StCapture  = 3'd4
    } state_e;

    function automatic logic cmd_is_valid(input logic [2:0] cmd);
        return (cmd == CMD_SHA256) || (cmd == CMD_XMSS);
    endfunction

endpackage

// File: rtl/sha256_bus_loader_result.sv
// Result capture register file: RES_WORDS x 32-bit words loaded from the
// 256-bit digest in one cycle, word 0 taken from the most significant bits.
//   clk_i, rst_ni  : clock and synchronous active-low reset
//   capture_i      : load all words from output_data_i this cycle
//   output_data_i  : digest from the hashing wrapper
//   rd_idx_i       : word index to read
//   rd_word_o      : selected result word (combinational)
module sha256_bus_loader_result #(
    parameter int unsigned RES_WORDS = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         capture_i,
    input  logic [32*RES_WORDS-1:0]      output_data_i,
    input  logic [$clog2(RES_WORDS)-1:0] rd_idx_i,
    output logic [31:0]                  rd_word_o
);

    logic [31:0] res_q [RES_WORDS];
    logic [31:0] res_d [RES_WORDS];

    always_comb begin
        for (int unsigned j = 0; j < RES_WORDS; j++) begin
            res_d[j] = res_q[j];
            if (capture_i) begin
                res_d[j] = output_data_i[32*RES_WORDS-1 - 32*j -: 32];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned j = 0; j < RES_WORDS; j++) begin
                res_q[j] <= '0;
            end
        end else begin
            res_q <= res_d;
        end
    end

    assign rd_word_o = res_q[rd_idx_i];

endmodule

// File: rtl/sha256_bus_loader.sv
// Bus-side loader for the SHA-256/XMSS hashing wrapper. Collects the 1024-bit
// input block from 32-bit word writes, latches the command and level flags,
// issues one-cycle start/init pulses, tracks the wrapper's busy/done handshake
// and captures the 256-bit digest into readable result words.
//   io_mainClk, io_systemReset : clock, synchronous active-low reset
//   bus_wr_*                   : write port (0..31 data, 32 command, 33 clear)
//   bus_rd_addr/bus_rd_data    : read port (0..7 result words, 8 status)
//   cmd_reg, input_data_reg    : command code and assembled block to wrapper
//   *_start_reg, *_init_*      : single-cycle pulses to wrapper
//   sha256XMSS_* level flags   : latched from command bits 6..9
//   sha256XMSS_done, module_busy, output_data : wrapper feedback
//   irq                        : high while result_valid or error
module sha256_bus_loader
    import sha256_bus_loader_pkg::*;
#(
    parameter int unsigned WORDS        = 32,
    parameter int unsigned RES_WORDS    = 8,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic          io_mainClk,
    input  logic          io_systemReset,
    input  logic          bus_wr_valid,
    output logic          bus_wr_ready,
    input  logic [5:0]    bus_wr_addr,
    input  logic [31:0]   bus_wr_data,
    input  logic [3:0]    bus_rd_addr,
    output logic [31:0]   bus_rd_data,
    output logic [2:0]    cmd_reg,
    output logic [1023:0] input_data_reg,
    output logic          sha256XMSS_start_reg,
    output logic          sha256_sha256_start_reg,
    output logic          sha256XMSS_init_iv,
    output logic          sha256_sha256_init_iv,
    output logic          sha256_sha256_init_message,
    output logic          sha256XMSS_second_block_data_available,
    output logic          sha256XMSS_message_length,
    output logic          sha256XMSS_store_intermediate,
    output logic          sha256XMSS_continue_intermediate,
    input  logic          sha256XMSS_done,
    input  logic [255:0]  output_data,
    input  logic          module_busy,
    output logic          irq
);

    localparam int unsigned    CntW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(BUSY_TIMEOUT);

    state_e          state_q, state_d;
    logic [1023:0]   input_data_q, input_data_d;
    logic [2:0]      cmd_q, cmd_d;
    logic            second_block_q, second_block_d;
    logic            msg_len_q, msg_len_d;
    logic            store_int_q, store_int_d;
    logic            cont_int_q, cont_int_d;
    logic            sha_start_q, sha_start_d;
    logic            xmss_start_q, xmss_start_d;
    logic            sha_iv_q, sha_iv_d;
    logic            xmss_iv_q, xmss_iv_d;
    logic            sha_msg_q, sha_msg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            capture;
    logic [31:0]     res_word;
    logic [31:0]     status;
    logic            is_sha, is_xmss;

    always_comb begin
        state_d        = state_q;
        input_data_d   = input_data_q;
        cmd_d          = cmd_q;
        second_block_d = second_block_q;
        msg_len_d      = msg_len_q;
        store_int_d    = store_int_q;
        cont_int_d     = cont_int_q;
        sha_start_d    = 1'b0;
        xmss_start_d   = 1'b0;
        sha_iv_d       = 1'b0;
        xmss_iv_d      = 1'b0;
        sha_msg_d      = 1'b0;
        cnt_d          = cnt_q;
        valid_d        = valid_q;
        err_d          = err_q;
        capture        = 1'b0;
        is_sha         = (bus_wr_data[2:0] == CMD_SHA256);
        is_xmss        = (bus_wr_data[2:0] == CMD_XMSS);

        unique case (state_q)
            StIdle: begin
                if (bus_wr_valid) begin
                    if ({26'd0, bus_wr_addr} < WORDS) begin
                        // Word 0 lands in the most significant 32 bits
                        for (int unsigned k = 0; k < WORDS; k++) begin
                            if (bus_wr_addr == 6'(k)) begin
                                input_data_d[1023 - 32*k -: 32] = bus_wr_data;
                            end
                        end
                    end else if (bus_wr_addr == ADDR_CMD) begin
                        cmd_d          = bus_wr_data[2:0];
                        second_block_d = bus_wr_data[CMD_BIT_SECOND_BLOCK];
                        msg_len_d      = bus_wr_data[CMD_BIT_MSG_LEN];
                        store_int_d    = bus_wr_data[CMD_BIT_STORE_INT];
                        cont_int_d     = bus_wr_data[CMD_BIT_CONT_INT];
                        if (bus_wr_data[CMD_BIT_START]) begin
                            if (cmd_is_valid(bus_wr_data[2:0])) begin
                                // Pulses are registered so they are high exactly
                                // during the LAUNCH cycle.
                                state_d      = StLaunch;
                                valid_d      = 1'b0;
                                err_d        = 1'b0;
                                sha_start_d  = is_sha;
                                xmss_start_d = is_xmss;
                                sha_iv_d     = is_sha & bus_wr_data[CMD_BIT_INIT_IV];
                                xmss_iv_d    = is_xmss & bus_wr_data[CMD_BIT_INIT_IV];
                                sha_msg_d    = is_sha & bus_wr_data[CMD_BIT_INIT_MSG];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end else if (bus_wr_addr == ADDR_CLR) begin
                        valid_d = 1'b0;
                        err_d   = 1'b0;
                    end
                end
            end
            StLaunch: begin
                state_d = StWaitBusy;
                cnt_d   = '0;
            end
            StWaitBusy: begin
                // A fast XMSS run may finish before busy is ever observed
                if ((cmd_q == CMD_XMSS) && sha256XMSS_done) begin
                    capture = 1'b1;
                    state_d = StCapture;
                end else if (module_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == TimeoutVal) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if ((cmd_q == CMD_XMSS) ? sha256XMSS_done : !module_busy) begin
                    capture = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Digest is sampled on the completion edge, so result_valid is visible
        // the cycle after done/busy-fall; CAPTURE is the settling cycle.
        if (capture) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge io_mainClk) begin
        if (!io_systemReset) begin
            state_q        <= StIdle;
            input_data_q   <= '0;
            cmd_q          <= '0;
            second_block_q <= 1'b0;
            msg_len_q      <= 1'b0;
            store_int_q    <= 1'b0;
            cont_int_q     <= 1'b0;
            sha_start_q    <= 1'b0;
            xmss_start_q   <= 1'b0;
            sha_iv_q       <= 1'b0;
            xmss_iv_q      <= 1'b0;
            sha_msg_q      <= 1'b0;
            cnt_q          <= '0;
            valid_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            input_data_q   <= input_data_d;
            cmd_q          <= cmd_d;
            second_block_q <= second_block_d;
            msg_len_q      <= msg_len_d;
            store_int_q    <= store_int_d;
            cont_int_q     <= cont_int_d;
            sha_start_q    <= sha_start_d;
            xmss_start_q   <= xmss_start_d;
            sha_iv_q       <= sha_iv_d;
            xmss_iv_q      <= xmss_iv_d;
            sha_msg_q      <= sha_msg_d;
            cnt_q          <= cnt_d;
            valid_q        <= valid_d;
            err_q          <= err_d;
        end
    end

    sha256_bus_loader_result #(
        .RES_WORDS(RES_WORDS)
    ) u_result (
        .clk_i        (io_mainClk),
        .rst_ni       (io_systemReset),
        .capture_i    (capture),
        .output_data_i(output_data),
        .rd_idx_i     (bus_rd_addr[2:0]),
        .rd_word_o    (res_word)
    );

    assign status = {25'd0, state_q, 1'b0, err_q, (state_q != StIdle), valid_q};

    always_comb begin
        bus_rd_data = '0;
        if ({28'd0, bus_rd_addr} < RES_WORDS) begin
            bus_rd_data = res_word;
        end else if (bus_rd_addr == ADDR_STATUS) begin
            bus_rd_data = status;
        end
    end

    assign bus_wr_ready                           = (state_q == StIdle);
    assign cmd_reg                                = cmd_q;
    assign input_data_reg                         = input_data_q;
    assign sha256XMSS_start_reg                   = xmss_start_q;
    assign sha256_sha256_start_reg                = sha_start_q;
    assign sha256XMSS_init_iv                     = xmss_iv_q;
    assign sha256_sha256_init_iv                  = sha_iv_q;
    assign sha256_sha256_init_message             = sha_msg_q;
    assign sha256XMSS_second_block_data_available = second_block_q;
    assign sha256XMSS_message_length              = msg_len_q;
    assign sha256XMSS_store_intermediate          = store_int_q;
    assign sha256XMSS_continue_intermediate       = cont_int_q;
    assign irq                                    = valid_q | err_q;

endmodule

// File: tb/tb_sha256_bus_loader.sv
module tb_sha256_bus_loader;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [5:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    rd_addr;
    logic [31:0]   rd_data;
    logic [2:0]    cmd;
    logic [1023:0] blk;
    logic          xmss_start, sha_start, xmss_iv, sha_iv, sha_msg;
    logic          f_second, f_len, f_store, f_cont;
    logic          xmss_done;
    logic [255:0]  out_data;
    logic          busy;
    logic          irq;

    always #5 clk = ~clk;

    sha256_bus_loader #(
        .WORDS(32),
        .RES_WORDS(8),
        .BUSY_TIMEOUT(16)
    ) dut (
        .io_mainClk                            (clk),
        .io_systemReset                        (rst_n),
        .bus_wr_valid                          (wr_valid),
        .bus_wr_ready                          (wr_ready),
        .bus_wr_addr                           (wr_addr),
        .bus_wr_data                           (wr_data),
        .bus_rd_addr                           (rd_addr),
        .bus_rd_data                           (rd_data),
        .cmd_reg                               (cmd),
        .input_data_reg                        (blk),
        .sha256XMSS_start_reg                  (xmss_start),
        .sha256_sha256_start_reg               (sha_start),
        .sha256XMSS_init_iv                    (xmss_iv),
        .sha256_sha256_init_iv                 (sha_iv),
        .sha256_sha256_init_message            (sha_msg),
        .sha256XMSS_second_block_data_available(f_second),
        .sha256XMSS_message_length             (f_len),
        .sha256XMSS_store_intermediate         (f_store),
        .sha256XMSS_continue_intermediate      (f_cont),
        .sha256XMSS_done                       (xmss_done),
        .output_data                           (out_data),
        .module_busy                           (busy),
        .irq                                   (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int sha_pulses = 0;
    int xmss_pulses = 0;

    always @(posedge clk) begin
        if (sha_start) sha_pulses++;
        if (xmss_start) xmss_pulses++;
    end

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t       rtab [16];
    logic [31:0]   abc [16];
    logic [31:0]   dig [8];
    logic [255:0]  digest_v;
    logic [255:0]  xmss_pat;
    logic [1023:0] exp_blk;
    logic [31:0]   v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int k = 0; k < 32; k++) begin
                if (act[1023 - 32*k -: 32] !== exp[1023 - 32*k -: 32]) begin
                    $display("FAIL %s: word %0d got %h want %h", nm, k,
                             act[1023 - 32*k -: 32], exp[1023 - 32*k -: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic chk_rd(input string nm, input logic [3:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(nm, rd_data, exp);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = 4'd8;
        xmss_done = 1'b0;
        out_data  = '0;
        busy      = 1'b0;

        abc = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
        dig = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        for (int j = 0; j < 8; j++) begin
            digest_v[255 - 32*j -: 32] = dig[j];
            xmss_pat[255 - 32*j -: 32] = 32'hA5A50000 | j;
        end
        for (int i = 0; i < 16; i++) begin
            rtab[i].addr = 4'(i);
            rtab[i].exp  = (i < 8) ? dig[i] : ((i == 8) ? 32'h00000001 : 32'h0);
        end
        exp_blk = '0;

        // Reset state
        tick();
        tick();
        chk_rd("rst_status", 4'd8, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_cmd", {29'd0, cmd}, 32'h0);
        chk("rst_ready", {31'd0, wr_ready}, 32'h1);
        chk_blk("rst_block", blk, exp_blk);
        rst_n = 1'b1;
        tick();

        // Plain SHA-256 "abc" run
        for (int i = 0; i < 16; i++) begin
            wr(6'(i), abc[i]);
            exp_blk[1023 - 32*i -: 32] = abc[i];
        end
        chk_blk("abc_block", blk, exp_blk);
        wr(6'd32, 32'h039);
        chk("sha_launch_pulses", {27'd0, xmss_start, sha_start, xmss_iv, sha_iv, sha_msg},
            32'h0B);
        chk("sha_launch_ready", {31'd0, wr_ready}, 32'h0);
        chk_rd("sha_launch_status", 4'd8, 32'h12);
        tick();
        chk("sha_pulse_width", {27'd0, xmss_start, sha_start, xmss_iv, sha_iv, sha_msg},
            32'h0);
        chk_rd("sha_waitbusy_status", 4'd8, 32'h22);
        busy = 1'b1;
        tick();
        chk_rd("sha_waitdone_status", 4'd8, 32'h32);
        repeat (5) tick();
        out_data = digest_v;
        busy     = 1'b0;
        tick();
        chk_rd("sha_capture_status", 4'd8, 32'h43);
        chk("sha_capture_irq", {31'd0, irq}, 32'h1);
        tick();
        chk_rd("sha_done_status", 4'd8, 32'h01);
        chk("sha_pulse_count", 32'(sha_pulses), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk_rd($sformatf("rd_addr_%0d", i), rtab[i].addr, rtab[i].exp);
        end

        // Level flags latched without start
        wr(6'd32, 32'h3C2);
        chk("flags_set", {28'd0, f_second, f_len, f_store, f_cont}, 32'hF);
        chk("flags_cmd", {29'd0, cmd}, 32'h2);
        chk_rd("flags_status", 4'd8, 32'h01);

        // XMSS run, done 40 cycles after start pulse, busy falls together with done
        wr(6'd32, 32'h00A);
        chk("xmss_launch_pulses", {27'd0, xmss_start, sha_start, xmss_iv, sha_iv, sha_msg},
            32'h10);
        chk("xmss_flags_cleared", {28'd0, f_second, f_len, f_store, f_cont}, 32'h0);
        chk_rd("xmss_launch_status", 4'd8, 32'h12);
        for (int i = 1; i < 40; i++) begin
            tick();
            if (i == 1) busy = 1'b1;
            if (i == 20) chk_rd("xmss_running_status", 4'd8, 32'h32);
        end
        out_data  = xmss_pat;
        xmss_done = 1'b1;
        busy      = 1'b0;
        tick();
        xmss_done = 1'b0;
        chk_rd("xmss_capture_status", 4'd8, 32'h43);
        tick();
        chk_rd("xmss_done_status", 4'd8, 32'h01);
        tick();
        chk_rd("xmss_idle_status", 4'd8, 32'h01);
        chk("xmss_pulse_count", 32'(xmss_pulses), 32'd1);
        chk_rd("xmss_res0", 4'd0, 32'hA5A50000);
        chk_rd("xmss_res7", 4'd7, 32'hA5A50007);

        // Busy never asserts: error at BUSY_TIMEOUT+2 cycles after command
        wr(6'd32, 32'h039);
        repeat (17) tick();
        chk_rd("timeout_pending", 4'd8, 32'h22);
        tick();
        chk_rd("timeout_status", 4'd8, 32'h04);
        chk("timeout_irq", {31'd0, irq}, 32'h1);
        wr(6'd33, 32'h0);
        chk_rd("clear_status", 4'd8, 32'h0);
        chk("clear_irq", {31'd0, irq}, 32'h0);

        // Invalid command code with start
        wr(6'd32, 32'h00F);
        chk("bad_cmd_pulses", {30'd0, xmss_start, sha_start}, 32'h0);
        chk_rd("bad_cmd_status", 4'd8, 32'h04);
        chk("bad_cmd_reg", {29'd0, cmd}, 32'h7);
        wr(6'd33, 32'h0);
        chk_rd("bad_cmd_clear", 4'd8, 32'h0);

        // Data write stalls while the run is in progress
        wr(6'd32, 32'h039);
        tick();
        busy = 1'b1;
        tick();
        wr_valid = 1'b1;
        wr_addr  = 6'd0;
        wr_data  = 32'hDEADBEEF;
        #1;
        chk("stall_ready", {31'd0, wr_ready}, 32'h0);
        tick();
        tick();
        chk_blk("stall_block_held", blk, exp_blk);
        out_data = digest_v;
        busy     = 1'b0;
        tick();
        chk("stall_capture_ready", {31'd0, wr_ready}, 32'h0);
        tick();
        chk("stall_idle_ready", {31'd0, wr_ready}, 32'h1);
        chk_blk("stall_block_idle", blk, exp_blk);
        tick();
        wr_valid = 1'b0;
        exp_blk[1023 -: 32] = 32'hDEADBEEF;
        chk_blk("stall_block_written", blk, exp_blk);

        // Reset in WAIT_DONE aborts and clears everything
        wr(6'd32, 32'h3F9);
        tick();
        busy = 1'b1;
        tick();
        chk_rd("pre_reset_status", 4'd8, 32'h32);
        rst_n = 1'b0;
        tick();
        chk_rd("mid_reset_status", 4'd8, 32'h0);
        chk("mid_reset_outs", {20'd0, irq, cmd, xmss_start, sha_start, xmss_iv, sha_iv,
            sha_msg, f_second, f_len, f_store, f_cont}, 32'h0);
        chk_blk("mid_reset_block", blk, '0);
        chk_rd("mid_reset_res0", 4'd0, 32'h0);
        chk_rd("mid_reset_res7", 4'd7, 32'h0);
        busy  = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_rd("post_reset_status", 4'd8, 32'h0);
        chk("post_reset_ready", {31'd0, wr_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
